ball_ctrl: RTL and testbench

- Ball controller for the brick-breaker game; the consumer end of the paddle geometry interface.
- Takes paddle_x/paddle_y/paddle_width/paddle_height plus the VGA scan position.
- Produces ball position, ball pixel colour and a lost-ball event.
- Runs a serve/move/lost state machine. Moves the ball on a divided movement tick and bounces it off the walls and the paddle.

---
 rtl/ball_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ball_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ball_ctrl.sv
// Brick-breaker ball controller: serve/move/lost FSM, wall and paddle bounces, ball pixel output.
// Optional feature macro BALL_SPEEDUP_EN: halves the movement tick period after four paddle hits.
module ball_ctrl #(
  parameter int unsigned TICK_DIV  = 208333,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        launch,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_pixels,
  input  logic [9:0]  paddle_x,
  input  logic [9:0]  paddle_y,
  input  logic [9:0]  paddle_width,
  input  logic [9:0]  paddle_height,
  output logic [23:0] vga_color,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic        ball_lost,
  output logic [1:0]  ball_state
);

  localparam logic [19:0] TICK_FULL = 20'(TICK_DIV);
  localparam logic [10:0] SZ        = 11'(BALL_SIZE);
  localparam logic [10:0] SW        = 11'(SCREEN_W);
  localparam logic [10:0] SH        = 11'(SCREEN_H);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_MOVE  = 2'd1,
    ST_LOST  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [19:0] r_cnt, w_cmp;
  logic        w_tick;
  logic [9:0]  r_ball_x, r_ball_y, w_bx_nxt, w_by_nxt;
  logic        r_dx_left, r_dy_down, w_dxl_nxt, w_dyd_nxt, w_dxl_flip, w_dyd_flip;
  logic        r_lost, w_lost_nxt;
  logic [10:0] w_bx, w_by, w_bx_end, w_by_end, w_px, w_py, w_pw, w_pad_end;
  logic [9:0]  w_serve_x, w_serve_y;
  logic        w_hit, w_hit_left, w_bottom, w_draw;
  logic        w_unused_height;

  assign w_unused_height = ^paddle_height;

  // 11-bit geometry so right/bottom edge sums never wrap
  assign w_bx      = {1'b0, r_ball_x};
  assign w_by      = {1'b0, r_ball_y};
  assign w_px      = {1'b0, paddle_x};
  assign w_py      = {1'b0, paddle_y};
  assign w_pw      = {1'b0, paddle_width};
  assign w_bx_end  = w_bx + SZ;
  assign w_by_end  = w_by + SZ;
  assign w_pad_end = w_px + w_pw;
  assign w_serve_x = 10'(w_px + ((w_pw - SZ) >> 1));
  assign w_serve_y = paddle_y - 10'(BALL_SIZE);

  assign w_hit      = r_dy_down && (w_by_end == w_py) && (w_bx_end > w_px) && (w_bx < w_pad_end);
  assign w_hit_left = (w_bx + (SZ >> 1)) < (w_px + (w_pw >> 1));
  assign w_bottom   = w_by_end >= SH;

`ifdef BALL_SPEEDUP_EN
  logic [2:0] r_hits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hits <= '0;
    end else if (r_state == ST_MOVE && w_tick) begin
      if (w_bottom)
        r_hits <= '0;
      else if (w_hit && r_hits != 3'd7)
        r_hits <= r_hits + 3'd1;
    end
  end

  assign w_cmp = (r_hits >= 3'd4) ? (TICK_FULL >> 1) : TICK_FULL;
`else
  assign w_cmp = TICK_FULL;
`endif

  assign w_tick = (r_cnt == w_cmp);

  // Wall flips first; a paddle hit then overrides the horizontal direction
  always_comb begin
    w_dxl_flip = r_dx_left;
    w_dyd_flip = r_dy_down;
    if (r_dx_left && r_ball_x == '0)  w_dxl_flip = 1'b0;
    if (!r_dx_left && w_bx_end >= SW) w_dxl_flip = 1'b1;
    if (!r_dy_down && r_ball_y == '0) w_dyd_flip = 1'b1;
    if (w_hit) begin
      w_dyd_flip = 1'b0;
      w_dxl_flip = w_hit_left;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bx_nxt    = r_ball_x;
    w_by_nxt    = r_ball_y;
    w_dxl_nxt   = r_dx_left;
    w_dyd_nxt   = r_dy_down;
    w_lost_nxt  = 1'b0;
    case (r_state)
      ST_SERVE: begin
        w_bx_nxt  = w_serve_x;
        w_by_nxt  = w_serve_y;
        w_dxl_nxt = 1'b0;
        w_dyd_nxt = 1'b0;
        if (launch) w_state_nxt = ST_MOVE;
      end
      ST_MOVE: begin
        if (w_tick) begin
          if (w_bottom) begin
            w_state_nxt = ST_LOST;
            w_lost_nxt  = 1'b1;
          end else begin
            w_dxl_nxt = w_dxl_flip;
            w_dyd_nxt = w_dyd_flip;
            w_bx_nxt  = w_dxl_flip ? r_ball_x - 10'd1 : r_ball_x + 10'd1;
            w_by_nxt  = w_dyd_flip ? r_ball_y + 10'd1 : r_ball_y - 10'd1;
          end
        end
      end
      ST_LOST: begin
        if (w_tick && !launch) w_state_nxt = ST_SERVE;
      end
      default: w_state_nxt = ST_SERVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_state   <= ST_SERVE;
      r_ball_x  <= 10'd316;
      r_ball_y  <= 10'd432;
      r_dx_left <= 1'b0;
      r_dy_down <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      r_cnt     <= w_tick ? '0 : r_cnt + 20'd1;
      r_state   <= w_state_nxt;
      r_ball_x  <= w_bx_nxt;
      r_ball_y  <= w_by_nxt;
      r_dx_left <= w_dxl_nxt;
      r_dy_down <= w_dyd_nxt;
      r_lost    <= w_lost_nxt;
    end
  end

  assign w_draw = active_pixels && (r_state != ST_LOST) &&
                  ({1'b0, x} >= w_bx) && ({1'b0, x} < w_bx_end) &&
                  ({1'b0, y} >= w_by) && ({1'b0, y} < w_by_end);

  assign vga_color  = w_draw ? 24'hFFFFFF : 24'd0;
  assign ball_x     = r_ball_x;
  assign ball_y     = r_ball_y;
  assign ball_lost  = r_lost;
  assign ball_state = r_state;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: game-rule model checked every cycle plus directed serve/bounce/paddle/loss scenarios.
module tb_ball_ctrl;

  localparam int TDIV = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        launch = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        active_pixels = 1'b0;
  logic [9:0]  paddle_x = 10'd270, paddle_y = 10'd440, paddle_width = 10'd100, paddle_height = 10'd10;
  logic [23:0] vga_color;
  logic [9:0]  ball_x, ball_y;
  logic        ball_lost;
  logic [1:0]  ball_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ball_ctrl #(.TICK_DIV(TDIV)) dut (
    .clk(clk), .rst(rst), .launch(launch), .x(x), .y(y), .active_pixels(active_pixels),
    .paddle_x(paddle_x), .paddle_y(paddle_y), .paddle_width(paddle_width),
    .paddle_height(paddle_height), .vga_color(vga_color), .ball_x(ball_x),
    .ball_y(ball_y), .ball_lost(ball_lost), .ball_state(ball_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Game-rule model: integer positions, direction as +1/-1, state 0/1/2
  int m_state = 0, m_bx = 316, m_by = 432, m_dx = 1, m_dy = -1, m_cnt = 0, m_hits = 0;
  bit m_lost = 0;

  always @(posedge clk or negedge rst) begin : model
    int lim, ndx, ndy, px, py, pw;
    bit tick;
    if (!rst) begin
      m_state = 0; m_bx = 316; m_by = 432; m_dx = 1; m_dy = -1;
      m_cnt = 0; m_lost = 0; m_hits = 0;
    end else begin
      px = int'(paddle_x); py = int'(paddle_y); pw = int'(paddle_width);
      lim  = (m_hits >= 4) ? TDIV / 2 : TDIV;
      tick = (m_cnt == lim);
      m_cnt = tick ? 0 : m_cnt + 1;
      m_lost = 0;
      if (m_state == 0) begin
        m_bx = (px + (pw - 8) / 2) % 1024;
        m_by = (py - 8 + 1024) % 1024;
        m_dx = 1; m_dy = -1;
        if (launch) m_state = 1;
      end else if (m_state == 1) begin
        if (tick) begin
          if (m_by + 8 >= 480) begin
            m_state = 2; m_lost = 1; m_hits = 0;
          end else begin
            ndx = m_dx; ndy = m_dy;
            if (m_dx < 0 && m_bx == 0) ndx = 1;
            if (m_dx > 0 && m_bx + 8 >= 640) ndx = -1;
            if (m_dy < 0 && m_by == 0) ndy = 1;
            if (m_dy > 0 && m_by + 8 == py && m_bx + 8 > px && m_bx < px + pw) begin
              ndy = -1;
              ndx = (m_bx + 4 < px + pw / 2) ? -1 : 1;
`ifdef BALL_SPEEDUP_EN
              if (m_hits < 7) m_hits = m_hits + 1;
`endif
            end
            m_dx = ndx; m_dy = ndy;
            m_bx = m_bx + m_dx;
            m_by = m_by + m_dy;
          end
        end
      end else begin
        if (tick && !launch) m_state = 0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [23:0] evga;
    evga = (active_pixels && m_state != 2 &&
            int'(x) >= m_bx && int'(x) < m_bx + 8 &&
            int'(y) >= m_by && int'(y) < m_by + 8) ? 24'hFFFFFF : 24'd0;
    check("model_ball_x", ball_x, m_bx);
    check("model_ball_y", ball_y, m_by);
    check("model_state", ball_state, m_state);
    check("model_lost", ball_lost, m_lost);
    check("model_vga", vga_color, evga);
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    // Reset values and pixel drawing while held in reset
    x = 10'd316; y = 10'd432; active_pixels = 1'b1;
    @(negedge clk);
    check("rst_ball_x", ball_x, 316);
    check("rst_ball_y", ball_y, 432);
    check("rst_state", ball_state, 0);
    check("rst_lost", ball_lost, 0);
    check("rst_vga_in", vga_color, 24'hFFFFFF);
    #1 x = 10'd324;
    #1 check("rst_vga_out", vga_color, 0);

    // Serve tracks paddle; launch; first tick
    rst = 1'b1; paddle_x = 10'd100;
    @(negedge clk);
    check("serve_track_x", ball_x, 146);
    check("serve_track_y", ball_y, 432);
    #1 launch = 1'b1;
    @(negedge clk);
    check("launch_state", ball_state, 1);
    #1 launch = 1'b0;
    for (k = 0; k < 30; k++) begin @(negedge clk); if (ball_x != 10'd146) break; end
    check("first_tick_seen", k < 30, 1);
    check("first_tick_x", ball_x, 147);
    check("first_tick_y", ball_y, 431);

    // Reset mid-move returns immediately, no loss pulse
    #1 rst = 1'b0;
    #1;
    check("midrst_x", ball_x, 316);
    check("midrst_y", ball_y, 432);
    check("midrst_state", ball_state, 0);
    check("midrst_lost", ball_lost, 0);

    // Corner: right wall and top together
    paddle_x = 10'd600; paddle_y = 10'd8; paddle_width = 10'd72;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("corner_serve_x", ball_x, 632);
    check("corner_serve_y", ball_y, 0);
    #1 launch = 1'b1;
    @(negedge clk);
    #1 launch = 1'b0;
    for (k = 0; k < 30; k++) begin @(negedge clk); if (ball_y != 10'd0) break; end
    check("corner_tick_seen", k < 30, 1);
    check("corner_x", ball_x, 631);
    check("corner_y", ball_y, 1);

    // Paddle hit: serve at (552,0), right-wall bounce brings ball to (280,432) moving down-left
    #1 rst = 1'b0;
    paddle_x = 10'd520; paddle_y = 10'd8; paddle_width = 10'd72;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("hit_serve_x", ball_x, 552);
    #1 launch = 1'b1;
    @(negedge clk);
    #1 launch = 1'b0;
    paddle_x = 10'd270; paddle_y = 10'd440; paddle_width = 10'd100;
    for (k = 0; k < 5000; k++) begin @(negedge clk); if (ball_y == 10'd432) break; end
    check("hit_reach_seen", k < 5000, 1);
    check("hit_pre_x", ball_x, 280);
    for (k = 0; k < 30; k++) begin @(negedge clk); if (ball_y != 10'd432) break; end
    check("hit_tick_seen", k < 30, 1);
    check("hit_y", ball_y, 431);
    check("hit_x", ball_x, 279);

    // Loss: paddle out of the way; ball walks to (624,472) and drops out the bottom
    #1 paddle_x = 10'd0; paddle_y = 10'd0; paddle_width = 10'd16;
    x = 10'd624; y = 10'd472; active_pixels = 1'b1;
    for (k = 0; k < 12000; k++) begin @(negedge clk); if (ball_lost) break; end
    check("lost_seen", k < 12000, 1);
    check("lost_state", ball_state, 2);
    check("lost_x", ball_x, 624);
    check("lost_y", ball_y, 472);
    check("lost_vga_hidden", vga_color, 0);
    @(negedge clk);
    check("lost_pulse_one", ball_lost, 0);
    #1 launch = 1'b1;
    repeat (30) @(negedge clk);
    check("lost_hold_launch", ball_state, 2);
    #1 launch = 1'b0;
    for (k = 0; k < 15; k++) begin @(negedge clk); if (ball_state == 2'd0) break; end
    check("reserve_seen", k < 15, 1);
    @(negedge clk);
    check("reserve_x", ball_x, 4);
    check("reserve_y", ball_y, 1016);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
